// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - key press/long-press/auto-repeat/release event generator
// Ports repeat_pulse/release_pulse carry the repeat/release events (both names are reserved words).
module key_event_gen #(
    parameter logic sim     = 1'b0,
    parameter int   long_ms = 1000,
    parameter int   rep_ms  = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic       press,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       release_pulse,
    output logic       held,
    output logic [7:0] rep_cnt
);

    localparam int         DIV       = sim ? 2 : 100000;
    localparam logic [16:0] DIV_LAST  = 17'(DIV - 1);
    localparam logic [9:0]  LONG_LAST = 10'(long_ms - 1);
    localparam logic [9:0]  REP_LAST  = 10'(rep_ms - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t      state, state_nx;
    logic [16:0] div_cnt;
    logic        tick;
    logic        in_d;
    logic        rise, fall;
    logic [9:0]  ms_cnt, ms_nx;
    logic [7:0]  rep_nx;
    logic        press_nx, long_nx, repeat_nx, release_nx, held_nx;

    // free-running ms tick; only reset ever clears it
    assign tick = (div_cnt == DIV_LAST);
    assign rise = in & ~in_d;
    assign fall = ~in & in_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt       <= '0;
            in_d          <= 1'b1;
            state         <= IDLE;
            ms_cnt        <= '0;
            rep_cnt       <= '0;
            press         <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
        end else begin
            div_cnt       <= tick ? '0 : div_cnt + 17'd1;
            in_d          <= in;
            state         <= state_nx;
            ms_cnt        <= ms_nx;
            rep_cnt       <= rep_nx;
            press         <= press_nx;
            long_press    <= long_nx;
            repeat_pulse  <= repeat_nx;
            release_pulse <= release_nx;
            held          <= held_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rise) state_nx = HOLD;
            HOLD: begin
                if (fall)                              state_nx = IDLE;
                else if (tick && ms_cnt == LONG_LAST)  state_nx = REPEAT;
            end
            REPEAT:  if (fall) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // fall is checked first so a release on the long/repeat edge suppresses that event
    always_comb begin
        press_nx   = 1'b0;
        long_nx    = 1'b0;
        repeat_nx  = 1'b0;
        release_nx = 1'b0;
        ms_nx      = ms_cnt;
        rep_nx     = rep_cnt;
        case (state)
            IDLE: begin
                if (rise) begin
                    press_nx = 1'b1;
                    ms_nx    = '0;
                    rep_nx   = '0;
                end
            end
            HOLD: begin
                if (fall) begin
                    release_nx = 1'b1;
                    ms_nx      = '0;
                end else if (tick) begin
                    if (ms_cnt == LONG_LAST) begin
                        long_nx = 1'b1;
                        ms_nx   = '0;
                    end else begin
                        ms_nx = ms_cnt + 10'd1;
                    end
                end
            end
            REPEAT: begin
                if (fall) begin
                    release_nx = 1'b1;
                    ms_nx      = '0;
                end else if (tick) begin
                    if (ms_cnt == REP_LAST) begin
                        repeat_nx = 1'b1;
                        ms_nx     = '0;
                        if (rep_cnt != 8'd255) rep_nx = rep_cnt + 8'd1;
                    end else begin
                        ms_nx = ms_cnt + 10'd1;
                    end
                end
            end
            default: ms_nx = '0;
        endcase
        held_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - scoreboard bench for key_event_gen (sim tick, long=4, rep=2; saturation unit long=1, rep=1)
module tb_key_event_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       in, in1;
    logic       press, long_press, repeat_pulse, release_pulse, held;
    logic [7:0] rep_cnt;
    logic       press1, long1, repeat1, release1, held1;
    logic [7:0] rep_cnt1;

    always #5 clk = ~clk;

    key_event_gen #(.sim(1'b1), .long_ms(4), .rep_ms(2)) dut (
        .clk(clk), .reset(reset), .in(in),
        .press(press), .long_press(long_press), .repeat_pulse(repeat_pulse),
        .release_pulse(release_pulse), .held(held), .rep_cnt(rep_cnt)
    );

    key_event_gen #(.sim(1'b1), .long_ms(1), .rep_ms(1)) dut_sat (
        .clk(clk), .reset(reset), .in(in1),
        .press(press1), .long_press(long1), .repeat_pulse(repeat1),
        .release_pulse(release1), .held(held1), .rep_cnt(rep_cnt1)
    );

    // kind: 1 press, 2 long_press, 3 repeat, 4 release; rel => window is delay from previous event
    typedef struct {
        int kind;
        int rep;
        int lo;
        int hi;
        bit rel;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   n_rep1 = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic push(input int kind, input int rep, input int lo, input int hi, input bit rel);
        exp_t e;
        e.kind = kind; e.rep = rep; e.lo = lo; e.hi = hi; e.rel = rel;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            int   nev, kind;
            exp_t e;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            nev = int'(press) + int'(long_press) + int'(repeat_pulse) + int'(release_pulse);
            if (nev != 0) begin
                chk_rng("one_hot_events", nev, 1, 1);
                kind = press ? 1 : long_press ? 2 : repeat_pulse ? 3 : 4;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", kind, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("event_rep_cnt", int'(rep_cnt), e.rep);
                    chk("event_held", int'(held), (kind == 4) ? 0 : 1);
                    if (e.rel) chk_rng("event_delay", cyc - last_cyc, e.lo, e.hi);
                    else       chk_rng("event_cycle", cyc, e.lo, e.hi);
                end
                last_cyc = cyc;
            end
            if (repeat1) n_rep1++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_press"},   int'(press), 0);
        chk({tag, "_long"},    int'(long_press), 0);
        chk({tag, "_repeat"},  int'(repeat_pulse), 0);
        chk({tag, "_release"}, int'(release_pulse), 0);
        chk({tag, "_held"},    int'(held), 0);
        chk({tag, "_rep_cnt"}, int'(rep_cnt), 0);
    endtask

    initial begin
        reset = 1'b1;
        in    = 1'b0;
        in1   = 1'b0;
        step(3);
        chk_all_zero("reset");
        reset = 1'b0;
        cyc   = 0;
        step(3);

        // short press: press then release, no long_press
        in = 1'b1;
        push(1, 0, cyc + 1, cyc + 1, 1'b0);
        step(2);
        chk("short_held", int'(held), 1);
        step(3);
        in = 1'b0;
        push(4, 0, cyc + 1, cyc + 1, 1'b0);
        step(4);
        chk("short_queue_empty", exp_q.size(), 0);
        chk("short_rep_cnt", int'(rep_cnt), 0);
        chk("short_held_after", int'(held), 0);

        // long hold for 30 clk: long_press 7-8 clk after press, repeats every 4 clk
        in = 1'b1;
        push(1, 0, cyc + 1, cyc + 1, 1'b0);
        push(2, 0, 7, 8, 1'b1);
        for (int r = 1; r <= 5; r++) push(3, r, 4, 4, 1'b1);
        step(30);
        in = 1'b0;
        push(4, 5, cyc + 1, cyc + 1, 1'b0);
        step(4);
        chk("long_queue_empty", exp_q.size(), 0);
        chk("long_rep_cnt_kept", int'(rep_cnt), 5);
        chk("long_held_after", int'(held), 0);

        // race: fall sampled on the very edge the long_press condition is met
        if (cyc % 2 == 0) step(1);
        in = 1'b1;
        push(1, 0, cyc + 1, cyc + 1, 1'b0);
        step(8);
        in = 1'b0;
        push(4, 0, cyc + 1, cyc + 1, 1'b0);
        step(4);
        chk("race_queue_empty", exp_q.size(), 0);
        chk("race_held", int'(held), 0);
        step(4);
        chk("race_no_late_event", exp_q.size(), 0);

        // asynchronous reset during REPEAT: outputs drop at once, no release
        in = 1'b1;
        push(1, 0, cyc + 1, cyc + 1, 1'b0);
        push(2, 0, 7, 8, 1'b1);
        push(3, 1, 4, 4, 1'b1);
        step(14);
        chk("midrep_held_before", int'(held), 1);
        reset = 1'b1;
        #1;
        chk_all_zero("midrep_async");
        step(3);
        in = 1'b0;
        step(2);
        reset = 1'b0;
        step(4);
        chk("midrep_queue_empty", exp_q.size(), 0);

        // key held through reset: nothing until in drops and rises again
        in    = 1'b1;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(6);
        chk("held_thru_reset_held", int'(held), 0);
        in = 1'b0;
        step(2);
        in = 1'b1;
        push(1, 0, cyc + 1, cyc + 1, 1'b0);
        step(3);
        chk("held_thru_reset_press_seen", exp_q.size(), 0);
        in = 1'b0;
        push(4, 0, cyc + 1, cyc + 1, 1'b0);
        step(3);
        chk("held_thru_reset_queue_empty", exp_q.size(), 0);

        // rep_cnt saturation with long_ms=1, rep_ms=1
        n_rep1 = 0;
        in1 = 1'b1;
        step(520);
        chk("sat_rep_cnt_mid", int'(rep_cnt1), 255);
        n_rep1 = 0;
        step(80);
        chk_rng("sat_repeats_continue", n_rep1, 38, 41);
        chk("sat_rep_cnt_final", int'(rep_cnt1), 255);
        chk("sat_held", int'(held1), 1);
        in1 = 1'b0;
        step(3);
        chk("sat_released_held", int'(held1), 0);
        chk("sat_rep_cnt_kept", int'(rep_cnt1), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_gen.md
KEY_EVENT_GEN -- requirements
Module: key_event_gen

Interface
REQ-001 Parameter sim, default 1'b0: 1 selects the simulation tick divider (2 clk); 0 selects the board divider (100000 clk, 1 ms at 100 MHz).
REQ-002 Parameter long_ms, default 1000: hold time in ticks before long_press; legal range 1..1023.
REQ-003 Parameter rep_ms, default 200: auto-repeat period in ticks after long_press; legal range 1..1023.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port in, input, 1: debounced, clk-synchronous key level from the debounce stage; 1 means pressed.
REQ-007 Port press, output, 1: one-clk pulse on a key press.
REQ-008 Port long_press, output, 1: one-clk pulse when the hold reaches long_ms.
REQ-009 Port repeat, output, 1: one-clk pulse every rep_ms after long_press while still held.
REQ-010 Port release, output, 1: one-clk pulse on key release.
REQ-011 Port held, output, 1: level; 1 while the FSM is in HOLD or REPEAT.
REQ-012 Port rep_cnt, output, 8: count of repeat pulses in the current press; saturates at 255.

Function
REQ-013 Tick divider: counter runs 0..DIV-1 and wraps, with DIV = sim?2:100000 and a 17-bit counter; tick is high for the one cycle where the count equals DIV-1; the divider free-runs and is never cleared except by reset.
REQ-014 Edge detect: in_d is a register of in; rise = in & ~in_d; fall = ~in & in_d.
REQ-015 All event outputs and held are registered; each pulse is high for exactly the one cycle following the clock edge that sampled its condition.
REQ-016 FSM states are IDLE, HOLD and REPEAT.
REQ-017 IDLE on rise: go to HOLD, pulse press, clear ms_cnt, clear rep_cnt.
REQ-018 HOLD: ms_cnt (10 bits) increments on each tick; when tick and ms_cnt==long_ms-1, go to REPEAT, pulse long_press, clear ms_cnt.
REQ-019 REPEAT: ms_cnt increments on each tick; when tick and ms_cnt==rep_ms-1, pulse repeat, increment rep_cnt (saturating at 255), clear ms_cnt.
REQ-020 HOLD or REPEAT on fall: go to IDLE, pulse release, clear ms_cnt; rep_cnt holds its value until the next press.
REQ-021 If fall coincides with a long_press or repeat condition, fall wins: no long_press or repeat pulse, no rep_cnt increment.
REQ-022 Press timing: because the tick free-runs, first-tick latency varies by up to one tick period.
- long_press occurs long_ms-1 to long_ms ticks after press.
- Each subsequent repeat occurs exactly rep_ms ticks after the previous event.
REQ-023 At most one of press, long_press, repeat and release is high in any cycle.
REQ-024 A key press shorter than long_ms produces only press, then release; no long_press.

Reset
REQ-025 Reset asserted forces the following, asynchronously:
- state=IDLE, divider=0, ms_cnt=0, rep_cnt=0;
- press=long_press=repeat=release=held=0;
- in_d=1.
REQ-026 With in_d reset to 1, a key held through reset produces no event until in is seen 0 and then rises again.
REQ-027 Reset asserted mid-HOLD or mid-REPEAT aborts the press with no release pulse.

Verification (sim=1, long_ms=4, rep_ms=2, so tick every 2 clk)
REQ-028 Short press: in 0->1 for 5 clk, then 0 -> press 1 cycle after the rise edge; release 1 cycle after the fall edge; long_press never asserts; rep_cnt=0.
REQ-029 Long hold: in=1 for 30 clk -> press, then long_press 6-8 clk after press; repeat every 4 clk thereafter; held=1 throughout; rep_cnt increments by 1 per repeat.
REQ-030 Race: release the key on the exact edge where long_press would fire -> release pulse only; no long_press; state returns to IDLE.
REQ-031 Saturation: with rep_ms=1 and long_ms=1, hold for 600 clk -> rep_cnt stops at 255 while repeat pulses continue.
REQ-032 Reset with in held at 1, then reset deasserted -> no press; after in goes 0 then 1 -> press asserts once.
REQ-033 Mid-operation reset: assert reset during REPEAT -> all outputs 0 immediately (asynchronous), with no release pulse.
